// File: rtl/alu_exec_pkg.sv
// Shared definitions for the execute stage: ALU op codes (as emitted by the
// ALU control decoder, plus MUL) and the stage FSM states.
package alu_exec_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_LINK = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_exec_if.sv
// Request/response bundle between the ALU control decoder, the execute stage
// and the downstream consumer of the result.
interface alu_exec_if #(parameter int WIDTH = 32) ();

    logic             valid_i;
    logic             ready_o;
    logic [3:0]       ctrl_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             overflow_o;

    modport slave (
        input  valid_i, ctrl_i, src1_i, src2_i, ready_i,
        output ready_o, valid_o, result_o, zero_o, overflow_o
    );

    modport master (
        output valid_i, ctrl_i, src1_i, src2_i, ready_i,
        input  ready_o, valid_o, result_o, zero_o, overflow_o
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH clocks
// per product. done/product are presented combinationally on the final step.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] addend;
    logic [CW-1:0]    count_reg;
    logic             active_reg;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
        assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end

    assign acc_next = acc_reg + addend;
    // The step that takes count to WIDTH is the last one, so its sum is the product.
    assign done     = active_reg && (count_reg == CW'(WIDTH - 1));
    assign product  = acc_next;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            active_reg <= 1'b0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            count_reg  <= '0;
        end else if (start) begin
            active_reg <= 1'b1;
            mcand_reg  <= a;
            mplier_reg <= b;
            acc_reg    <= '0;
            count_reg  <= '0;
        end else if (active_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg + 1'b1;
            if (done) begin
                active_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Registered execute stage: single-cycle ALU ops plus an iterative MUL, with
// valid/ready handshakes on both the request and the result side.
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    alu_exec_if.slave  bus
);

    state_t           state_reg;
    state_t           state_next;
    logic             accept;
    logic             is_mul;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] result_reg;
    logic             ovf_reg;
    logic             zero_reg;

    // Accepting from DONE while the consumer drains lets ops issue back to back.
    assign bus.ready_o = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && bus.ready_i);
    assign accept      = bus.valid_i && bus.ready_o;
    assign is_mul      = (bus.ctrl_i == OP_MUL);
    assign mul_start   = accept && is_mul;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start   (mul_start),
        .a       (bus.src1_i),
        .b       (bus.src2_i),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = is_mul ? ST_BUSY : ST_DONE;
            end
            ST_BUSY: begin
                if (mul_done) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (accept)           state_next = is_mul ? ST_BUSY : ST_DONE;
                else if (bus.ready_i) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign sum     = bus.src1_i + bus.src2_i;
    assign diff    = bus.src1_i - bus.src2_i;
    assign add_ovf = (bus.src1_i[WIDTH-1] == bus.src2_i[WIDTH-1]) &&
                     (sum[WIDTH-1] != bus.src1_i[WIDTH-1]);
    assign sub_ovf = (bus.src1_i[WIDTH-1] != bus.src2_i[WIDTH-1]) &&
                     (diff[WIDTH-1] != bus.src1_i[WIDTH-1]);

    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        case (bus.ctrl_i)
            OP_AND:  alu_result = bus.src1_i & bus.src2_i;
            OP_OR:   alu_result = bus.src1_i | bus.src2_i;
            OP_ADD: begin
                alu_result = sum;
                alu_ovf    = add_ovf;
            end
            OP_SUB: begin
                alu_result = diff;
                alu_ovf    = sub_ovf;
            end
            // Signed less-than without a second comparator: sign of A-B corrected by overflow.
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
            OP_LINK: alu_result = bus.src1_i;
            OP_NOR:  alu_result = ~(bus.src1_i | bus.src2_i);
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            result_reg <= '0;
            ovf_reg    <= 1'b0;
            zero_reg   <= 1'b0;
        end else if (accept && !is_mul) begin
            result_reg <= alu_result;
            ovf_reg    <= alu_ovf;
            zero_reg   <= (alu_result == '0);
        end else if ((state_reg == ST_BUSY) && mul_done) begin
            result_reg <= mul_product;
            ovf_reg    <= 1'b0;
            zero_reg   <= (mul_product == '0);
        end
    end

    assign bus.valid_o    = (state_reg == ST_DONE);
    assign bus.result_o   = result_reg;
    assign bus.zero_o     = zero_reg;
    assign bus.overflow_o = ovf_reg;

endmodule

// File: tb/tb_alu_exec.sv
// Directed and randomized checks of alu_exec against an arithmetic reference
// model; one line is printed per transaction.
module tb_alu_exec;
    import alu_exec_pkg::*;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    alu_exec_if #(.WIDTH(32)) bus ();

    alu_exec #(.WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model straight from the op definitions, using 64-bit arithmetic.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic v);
        longint     sa = $signed(a);
        longint     sb = $signed(b);
        longint     s;
        logic [63:0] p;
        r = '0;
        v = 1'b0;
        s = 0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2: begin
                s = sa + sb;
                r = s[31:0];
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd3: begin
                p = {32'd0, a} * {32'd0, b};
                r = p[31:0];
            end
            4'd6: begin
                s = sa - sb;
                r = s[31:0];
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  r = a;
            4'd12: r = ~(a | b);
            default: r = '0;
        endcase
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.valid_i = 1'b1;
        bus.ctrl_i  = op;
        bus.src1_i  = a;
        bus.src2_i  = b;
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        ev;
        int          n;
        int          lat;
        model(op, a, b, er, ev);
        @(negedge clk);
        bus.ready_i = 1'b1;
        drive(op, a, b);
        n = 0;
        while (!bus.ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(bus.ready_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
        lat = 0;
        while (!bus.valid_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), (op == OP_MUL) ? 32'd32 : 32'd0);
        check({tag, "_result"}, bus.result_o, er);
        check({tag, "_ovf"}, 32'(bus.overflow_o), 32'(ev));
        check({tag, "_zero"}, 32'(bus.zero_o), 32'(er == 32'd0));
        $display("%s op=%0d a=%h b=%h -> result=%h ovf=%b zero=%b lat=%0d",
                 tag, op, a, b, bus.result_o, bus.overflow_o, bus.zero_o, lat);
    endtask

    logic [3:0]  seq_op [4];
    logic [31:0] seq_a  [4];
    logic [31:0] seq_b  [4];
    logic [3:0]  rnd_ops [10];

    initial begin
        logic [31:0] er;
        logic        ev;
        logic [31:0] held;
        int          vcount;

        rst = 1'b0;
        bus.valid_i = 1'b0;
        bus.ctrl_i  = '0;
        bus.src1_i  = '0;
        bus.src2_i  = '0;
        bus.ready_i = 1'b1;

        // Power-on reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("reset_valid", 32'(bus.valid_o), 32'd0);
        check("reset_result", bus.result_o, 32'd0);
        check("reset_zero", 32'(bus.zero_o), 32'd0);
        check("reset_ovf", 32'(bus.overflow_o), 32'd0);
        check("reset_ready", 32'(bus.ready_o), 32'd1);
        $display("reset released: valid=%b result=%h ready=%b", bus.valid_o, bus.result_o, bus.ready_o);

        // Reset in the middle of a MUL discards it
        @(negedge clk);
        drive(OP_MUL, 32'd1234, 32'd5678);
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("midmul_valid", 32'(bus.valid_o), 32'd0);
        check("midmul_result", bus.result_o, 32'd0);
        check("midmul_ready", 32'(bus.ready_o), 32'd1);
        vcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.valid_o) vcount++;
        end
        check("midmul_stale", 32'(vcount), 32'd0);
        $display("mid-MUL reset: stale valid cycles=%0d", vcount);

        // Directed single-cycle ops
        do_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        check("add_ovf_value", bus.result_o, 32'h8000_0000);
        check("add_ovf_flag", 32'(bus.overflow_o), 32'd1);
        do_op("sub_zero", OP_SUB, 32'd5, 32'd5);
        check("sub_zero_flag", 32'(bus.zero_o), 32'd1);
        do_op("slt_neg", OP_SLT, 32'hFFFF_FFFF, 32'd1);
        check("slt_neg_value", bus.result_o, 32'd1);
        do_op("slt_pos", OP_SLT, 32'd1, 32'hFFFF_FFFF);
        check("slt_pos_value", bus.result_o, 32'd0);
        do_op("nor", OP_NOR, 32'd0, 32'd0);
        check("nor_value", bus.result_o, 32'hFFFF_FFFF);
        do_op("link", OP_LINK, 32'h0040_0008, 32'h1234_5678);
        check("link_value", bus.result_o, 32'h0040_0008);
        do_op("undef", 4'd5, 32'hDEAD_BEEF, 32'h1);

        // MUL latency with ignored requests during BUSY
        @(negedge clk);
        bus.ready_i = 1'b1;
        drive(OP_MUL, 32'h0000_FFFF, 32'h0001_0001);
        @(posedge clk);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check("mul_busy_ready", 32'(bus.ready_o), 32'd0);
            check("mul_busy_valid", 32'(bus.valid_o), 32'd0);
            drive(OP_ADD, 32'd100, 32'd23);
            bus.valid_i = i[0];
        end
        @(negedge clk);
        bus.valid_i = 1'b0;
        check("mul_lat_valid", 32'(bus.valid_o), 32'd1);
        check("mul_lat_result", bus.result_o, 32'hFFFF_FFFF);
        $display("mul 0000ffff*00010001 -> result=%h valid=%b after 32 edges", bus.result_o, bus.valid_o);
        do_op("mul_neg", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mul_neg_value", bus.result_o, 32'd1);

        // Backpressure then same-edge issue
        @(negedge clk);
        bus.ready_i = 1'b0;
        drive(OP_OR, 32'h0F0F_0000, 32'h0000_00F0);
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
        held = 32'h0F0F_00F0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.valid_o), 32'd1);
            check("bp_result", bus.result_o, held);
            check("bp_ready", 32'(bus.ready_o), 32'd0);
            @(negedge clk);
        end
        bus.ready_i = 1'b1;
        drive(OP_ADD, 32'd40, 32'd2);
        #1;
        check("bp_release_ready", 32'(bus.ready_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
        check("bp_issue_valid", 32'(bus.valid_o), 32'd1);
        check("bp_issue_result", bus.result_o, 32'd42);
        $display("backpressure: held=%h then issued result=%h", held, bus.result_o);

        // Back-to-back stream
        seq_op = '{OP_AND, OP_OR, OP_ADD, OP_SUB};
        seq_a  = '{32'hFF00_FF00, 32'h1200_0034, 32'h8000_0000, 32'd3};
        seq_b  = '{32'h0FF0_0FF0, 32'h0056_7800, 32'h8000_0000, 32'd10};
        @(negedge clk);
        drive(seq_op[0], seq_a[0], seq_b[0]);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i < 3) drive(seq_op[i+1], seq_a[i+1], seq_b[i+1]);
            else       bus.valid_i = 1'b0;
            model(seq_op[i], seq_a[i], seq_b[i], er, ev);
            check("b2b_valid", 32'(bus.valid_o), 32'd1);
            check("b2b_result", bus.result_o, er);
            check("b2b_ovf", 32'(bus.overflow_o), 32'(ev));
            $display("b2b op=%0d -> result=%h ovf=%b", seq_op[i], bus.result_o, bus.overflow_o);
        end

        // Randomized ops
        rnd_ops = '{OP_AND, OP_OR, OP_ADD, OP_MUL, OP_SUB, OP_SLT, OP_LINK, OP_NOR, 4'd4, 4'd15};
        for (int i = 0; i < 150; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = rnd_ops[$urandom_range(0, 9)];
            if (op == OP_MUL && $urandom_range(0, 3) != 0) op = OP_SUB;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'h7FFF_FFFF;
                1: b = 32'h8000_0000;
                2: b = a;
                default: ;
            endcase
            do_op("rnd", op, a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Registered execute stage of the CPU datapath, directly downstream of the ALU control decoder. It accepts a 4-bit ALU operation code plus two 32-bit operands over a valid/ready handshake and returns the result, zero flag and signed-overflow flag over a second valid/ready handshake. Logic/arithmetic ops complete in one cycle. The new MUL op (code 3) runs as a 32-iteration shift-add sequence, so the stage can stall the pipeline.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; the MUL iteration count equals `WIDTH`.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-low.
- `valid_i`  in  1  operation request valid.
- `ready_o`  out  1  stage can accept a request this cycle.
- `ctrl_i`  in  4  op code: 0 AND, 1 OR, 2 ADD, 3 MUL, 6 SUB, 7 SLT, 8 LINK, 12 NOR.
- `src1_i`  in  WIDTH  operand A.
- `src2_i`  in  WIDTH  operand B.
- `valid_o`  out  1  result valid.
- `ready_i`  in  1  downstream accepts the result.
- `result_o`  out  WIDTH  registered result.
- `zero_o`  out  1  high when `result_o` is 0.
- `overflow_o`  out  1  signed overflow; ADD/SUB only, 0 for all other ops.

## Operation
- States: IDLE (no result held), BUSY (MUL iterating), DONE (result held, `valid_o` high).
- `ready_o` is high in IDLE. It is also high in DONE when `ready_i` is high, combinationally, which allows back-to-back issue. It is 0 in BUSY.
- A request is accepted on an edge where `valid_i` and `ready_o` are both high. The operands and `ctrl_i` are captured at that edge.
- Single-cycle ops (all codes except 3): the result is registered at the accept edge and the state goes to DONE.
- Single-cycle op arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - ADD overflow: both operands have the same sign and the result sign differs from them.
  - SUB overflow: the operands have different signs and the result sign differs from `src1_i`.
  - SLT: result is 1 if `src1_i` < `src2_i` (signed), else 0. Computed as sign(A−B) XOR overflow(A−B).
  - NOR: result is ~(A|B).
  - LINK: result is `src1_i` unchanged. This carries the return address for jal/jump.
- MUL:
  - At the accept edge, load multiplicand=A, multiplier=B, acc=0, count=0, and go to BUSY.
  - Each BUSY edge: if multiplier[0]=1, acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++.
  - When count reaches `WIDTH`, the result is acc (low `WIDTH` bits of the product, sign-agnostic) and the state goes to DONE.
- Undefined codes: result 0, flags 0, single-cycle.
- DONE with `ready_i` high:
  - If a new request is accepted on the same edge, load the new result (single-cycle op) or go to BUSY (MUL).
  - Otherwise go to IDLE.
- DONE with `ready_i` low: `result_o` and flags hold stable and `valid_o` stays high.
- `zero_o` is computed from the registered result.

## Timing
- Reset (`rst_i`=0 at an edge): state goes to IDLE.
  - `valid_o`, `result_o`, `zero_o` and `overflow_o` all go to 0.
  - `ready_o` reads 1 from the first post-reset cycle.
- Reset mid-MUL or with a held result: the operation or result is discarded and no `valid_o` is produced.
- Single-cycle op latency: request accepted at edge k, `valid_o`=1 from edge k.
- MUL latency: accepted at edge k, `valid_o`=1 from edge k+WIDTH (edge k+32 at the default). `ready_o`=0 for cycles k through k+WIDTH−1.
- Throughput: one single-cycle op per clock while `ready_i`=1. One MUL per WIDTH+1 clocks.
- `valid_i` asserted during BUSY: the request is ignored, and the upstream stage must hold it until `ready_o`=1.

## Structure
- Shared package `alu_exec_pkg` contains:
  - The op-code constants, the same values the ALU control decoder emits, plus MUL=3.
  - The state enum (IDLE/BUSY/DONE).
- Sub-module `alu_mul_iter` contains the shift-add datapath: multiplicand, multiplier, accumulator, counter, and `start`/`done` signals.
- The top level keeps the FSM, handshakes, the single-cycle ALU and output registers.

## Test plan
- Reset: hold `rst_i`=0 for 2 edges during a MUL, then release → `valid_o`=0, `result_o`=0, `ready_o`=1, no stale result emitted.
- ADD overflow: ADD 0x7FFFFFFF+1 → `result_o`=0x80000000, `overflow_o`=1, `valid_o` at the accept edge. SUB 5−5 → 0, `zero_o`=1.
- SLT, signed: SLT 0xFFFFFFFF vs 1 → 1. SLT 1 vs 0xFFFFFFFF → 0. NOR 0 vs 0 → 0xFFFFFFFF. LINK 0x00400008 → 0x00400008.
- MUL latency: MUL 0x0000FFFF×0x00010001 → 0xFFFFFFFF exactly 32 edges after accept. `ready_o`=0 throughout BUSY and `valid_i` pulses in BUSY are ignored. MUL 0xFFFFFFFF×0xFFFFFFFF → 1.
- Backpressure: hold `ready_i`=0 for 5 cycles after a result → `result_o`/`valid_o` stable. Raising `ready_i` with a new valid request issues the new op on the same edge.
- Back-to-back: AND, OR, ADD, SUB streamed with `ready_i`=1 → one result per clock, in order.
